// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM encoding,
// ALU16 control words and the shift-add multiplier iteration count.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Control word bit order: {zx, nx, zy, ny, f1, f0, no, cin}
  localparam logic [7:0] CTRL_ADD = 8'b0000_0000;
  localparam logic [7:0] CTRL_SUB = 8'b0001_0001;
  localparam logic [7:0] CTRL_AND = 8'b0000_1000;
  localparam logic [7:0] CTRL_OR  = 8'b0000_0100;
  localparam logic [7:0] CTRL_XOR = 8'b0000_1100;
  localparam logic [7:0] CTRL_NOT = 8'b0010_0010;
  localparam int CTRL_ZY_BIT = 5;

  localparam int MUL_ITERS = 16;

  function automatic logic [7:0] op_ctrl(input logic [2:0] op);
    logic [7:0] ctrl;
    case (op)
      OP_SUB:  ctrl = CTRL_SUB;
      OP_AND:  ctrl = CTRL_AND;
      OP_OR:   ctrl = CTRL_OR;
      OP_XOR:  ctrl = CTRL_XOR;
      OP_NOT:  ctrl = CTRL_NOT;
      default: ctrl = CTRL_ADD;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_seq_alu16.sv
// 16-bit Hack-style ALU: optional zero/invert on each input, add/and/or/xor,
// optional output invert. Carry-out is only meaningful for the add function.
module alu16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [7:0]  ctrl,
  output logic [15:0] out,
  output logic        cout
);

  logic zx, nx, zy, ny, f1, f0, no, cin;
  logic [15:0] xa, ya, fo;
  logic [16:0] sum;

  assign {zx, nx, zy, ny, f1, f0, no, cin} = ctrl;

  always_comb begin
    xa = zx ? 16'h0000 : x;
    if (nx) xa = ~xa;
    ya = zy ? 16'h0000 : y;
    if (ny) ya = ~ya;
    sum = {1'b0, xa} + {1'b0, ya} + {16'h0000, cin};
    case ({f1, f0})
      2'b10:   fo = xa & ya;
      2'b01:   fo = xa | ya;
      2'b11:   fo = xa ^ ya;
      default: fo = sum[15:0];
    endcase
    out  = no ? ~fo : fo;
    cout = ({f1, f0} == 2'b00) ? sum[16] : 1'b0;
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU controller: one-cycle ALU ops and a 16-iteration shift-add
// multiply, both sharing a single ALU16 instance, with a held response slot.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_cout,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic        busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // req_ready is high only in IDLE; rsp_valid stays high, with rsp_* frozen,
  // until the consumer raises rsp_ready.

  state_t      state, next_state;
  logic [2:0]  op_q;
  logic [15:0] a_q, b_q, hi, lo;
  logic [4:0]  cnt;
  logic        req_fire, mul_done;

  logic [15:0] alu_x, alu_y, alu_out;
  logic [7:0]  alu_ctrl;
  logic        alu_cout;

  assign req_ready = (state == S_IDLE) && rst_n;
  assign busy      = (state != S_IDLE);
  assign req_fire  = req_valid && req_ready;
  assign mul_done  = (cnt == 5'(MUL_ITERS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (req_fire) next_state = (req_op == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC: next_state = S_RESP;
      S_MUL:  if (mul_done) next_state = S_RESP;
      S_RESP: if (rsp_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // During MUL the ALU adds A to the partial product only when the current
  // multiplier bit is set; zeroing y otherwise avoids a separate mux.
  always_comb begin
    alu_x    = a_q;
    alu_y    = b_q;
    alu_ctrl = op_ctrl(op_q);
    if (state == S_MUL) begin
      alu_x    = hi;
      alu_y    = a_q;
      alu_ctrl = CTRL_ADD;
      alu_ctrl[CTRL_ZY_BIT] = ~lo[0];
    end
  end

  alu16 u_alu (
    .x    (alu_x),
    .y    (alu_y),
    .ctrl (alu_ctrl),
    .out  (alu_out),
    .cout (alu_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_fire) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
            hi   <= '0;
            lo   <= req_b;
            cnt  <= '0;
          end
        end
        S_EXEC: begin
          rsp_valid <= 1'b1;
          if (op_q == OP_ILL) begin
            rsp_data <= '0;
            rsp_cout <= 1'b0;
            rsp_zero <= 1'b1;
            rsp_err  <= 1'b1;
          end else begin
            rsp_data <= {16'h0000, alu_out};
            rsp_cout <= ((op_q == OP_ADD) || (op_q == OP_SUB)) && alu_cout;
            rsp_zero <= (alu_out == 16'h0000);
            rsp_err  <= 1'b0;
          end
        end
        S_MUL: begin
          if (mul_done) begin
            rsp_valid <= 1'b1;
            rsp_data  <= {hi, lo};
            rsp_cout  <= 1'b0;
            rsp_zero  <= ({hi, lo} == 32'h0);
            rsp_err   <= 1'b0;
          end else begin
            {hi, lo} <= {alu_cout, alu_out, lo[15:1]};
            cnt      <= cnt + 5'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a vector table of single ops plus hand-written
// sequences for reset, response back-pressure and reset during a multiply.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_cout, rsp_zero, rsp_err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] data;
    logic        cout;
    logic        zero;
    logic        err;
    int          lat;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout waiting on DUT", name);
  endtask

  // Offer a command from a falling edge; returns just after the accepting
  // rising edge, with req_* scrambled to expose any unlatched operand use.
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) timeout_fail("send");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom_range(0, 7));
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
  endtask

  // Counts rising edges after the accepting edge until rsp_valid is seen,
  // and how many sampled cycles had busy low while waiting.
  task automatic wait_rsp(output int lat, output int busy_lo);
    lat = 0;
    busy_lo = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 100) begin
      if (!busy) busy_lo++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!rsp_valid) timeout_fail("wait_rsp");
  endtask

  task automatic take_rsp(input string name);
    rsp_ready = 1'b1;
    #1;
    chk({name, " req_ready in RESP"}, 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat, blo;
    string nm;

    vecs[0]  = '{3'd0, 16'hFFFF, 16'h0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1};
    vecs[1]  = '{3'd1, 16'h0005, 16'h0007, 32'h0000_FFFE, 1'b0, 1'b0, 1'b0, 1};
    vecs[2]  = '{3'd4, 16'hF0F0, 16'h0FF0, 32'h0000_FF00, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{3'd2, 16'hF0F0, 16'h0FF0, 32'h0000_00F0, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{3'd3, 16'hF0F0, 16'h0FF0, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{3'd5, 16'h1234, 16'h9999, 32'h0000_EDCB, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{3'd0, 16'h1234, 16'h4321, 32'h0000_5555, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{3'd1, 16'h0007, 16'h0005, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1};
    vecs[8]  = '{3'd1, 16'h0005, 16'h0005, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1};
    vecs[9]  = '{3'd0, 16'hFFFF, 16'hFFFF, 32'h0000_FFFE, 1'b1, 1'b0, 1'b0, 1};
    vecs[10] = '{3'd6, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 1'b0, 1'b0, 17};
    vecs[11] = '{3'd6, 16'h1234, 16'h0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 17};
    vecs[12] = '{3'd6, 16'h1234, 16'h5678, 32'h0626_0060, 1'b0, 1'b0, 1'b0, 17};
    vecs[13] = '{3'd7, 16'h1234, 16'h5678, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1};
    vecs[14] = '{3'd0, 16'h0001, 16'h0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = 16'h0;
    req_b     = 16'h0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rsp_data", rsp_data, 32'h0);
    chk("rst flags", {29'd0, rsp_cout, rsp_zero, rsp_err}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post-rst req_ready", 32'(req_ready), 32'd1);

    // Vector table: EXEC ops land two cycles after the handshake cycle
    // (one edge later), MUL ops eighteen (seventeen edges later).
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_rsp(lat, blo);
      nm = $sformatf("v%0d", i);
      chk({nm, " latency"}, 32'(lat), 32'(vecs[i].lat));
      chk({nm, " busy"}, 32'(blo), 32'd0);
      chk({nm, " data"}, rsp_data, vecs[i].data);
      chk({nm, " cout"}, 32'(rsp_cout), 32'(vecs[i].cout));
      chk({nm, " zero"}, 32'(rsp_zero), 32'(vecs[i].zero));
      chk({nm, " err"}, 32'(rsp_err), 32'(vecs[i].err));
      take_rsp(nm);
    end

    // Back-pressure: response held for 10 cycles while a new command waits.
    send(3'd0, 16'h0002, 16'h0003);
    wait_rsp(lat, blo);
    chk("stall latency", 32'(lat), 32'd1);
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_a     = 16'h0007;
    req_b     = 16'h0008;
    for (int k = 0; k < 10; k++) begin
      nm = $sformatf("stall c%0d", k);
      chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, " data"}, rsp_data, 32'h0000_0005);
      chk({nm, " flags"}, {29'd0, rsp_cout, rsp_zero, rsp_err}, 32'd0);
      chk({nm, " req_ready"}, 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    take_rsp("stall");
    @(negedge clk);
    chk("stall next req_ready", 32'(req_ready), 32'd1);
    chk("stall next busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_rsp(lat, blo);
    chk("queued latency", 32'(lat), 32'd1);
    chk("queued data", rsp_data, 32'h0000_000F);
    take_rsp("queued");

    // Reset in the middle of a multiply, then a clean ADD.
    send(3'd6, 16'hFFFF, 16'hFFFF);
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midmul rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midmul busy", 32'(busy), 32'd0);
    chk("midmul req_ready", 32'(req_ready), 32'd0);
    chk("midmul rsp_data", rsp_data, 32'h0);
    chk("midmul flags", {29'd0, rsp_cout, rsp_zero, rsp_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midmul post req_ready", 32'(req_ready), 32'd1);
    send(3'd0, 16'h0002, 16'h0003);
    wait_rsp(lat, blo);
    chk("after-rst latency", 32'(lat), 32'd1);
    chk("after-rst data", rsp_data, 32'h0000_0005);
    chk("after-rst flags", {29'd0, rsp_cout, rsp_zero, rsp_err}, 32'd0);
    take_rsp("after-rst");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter: none; widths fixed (operand 16, result 32, op 3).
REQ-002 SHALL have the following ports. There is one clock, and reset is asynchronous, active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  command offered
- req_ready  out  1  controller accepts command this cycle
- req_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(a), 6 MUL (unsigned 16x16), 7 illegal
- req_a  in  16  operand A
- req_b  in  16  operand B
- rsp_valid  out  1  result held
- rsp_ready  in  1  consumer takes result
- rsp_data  out  32  result; bits 31:16 are zero except for MUL
- rsp_cout  out  1  adder carry-out for ADD/SUB, else 0
- rsp_zero  out  1  rsp_data == 0
- rsp_err  out  1  illegal op
- busy  out  1  state != IDLE

Function
REQ-003 SHALL implement FSM states IDLE, EXEC, MUL, RESP.
REQ-004 SHALL assert req_ready only in IDLE; a handshake occurs when req_valid && req_ready; op/a/b are latched on that edge.
REQ-005 IDLE SHALL transition on handshake to MUL for op 6, else to EXEC.
REQ-006 EXEC SHALL last one cycle: ALU evaluates latched operands, result/flags registered, -> RESP; handshake at cycle N gives rsp_valid at N+2.
REQ-007 ALU controls SHALL be {zx,nx,zy,ny,f1,f0,no,cin} with x=A and y=B, as follows:
- ADD = 0,0,0,0,0,0,0,0
- SUB (A-B) = 0,0,0,1,0,0,0,1
- AND = 0,0,0,0,1,0,0,0
- OR = 0,0,0,0,0,1,0,0
- XOR = 0,0,0,0,1,1,0,0
- NOT = 0,0,1,0,0,0,1,0
REQ-008 SUB rsp_cout SHALL be the raw adder carry (1 = no borrow).
REQ-009 Illegal op SHALL take the EXEC path without using the ALU result: rsp_data=0, rsp_err=1, rsp_zero=1, rsp_cout=0.
REQ-010 MUL SHALL initialise hi=0, lo=B, cnt=0 on handshake.
REQ-011 MUL SHALL run 16 iteration cycles. Each iteration:
- ALU x=hi, y=A, ADD controls with zy=~lo[0].
- {hi,lo} <= {cout, sum, lo[15:1]}.
- cnt++.
REQ-012 After iteration 16, MUL SHALL transition to RESP with rsp_data={hi,lo}; rsp_valid at N+18, i.e. 16 iteration cycles plus a register stage; rsp_cout=0.
REQ-013 RESP SHALL hold rsp_valid and all rsp_* stable until rsp_ready; on handshake -> IDLE.
REQ-014 req_ready SHALL be 0 in the RESP cycle even when rsp_ready=1; the next command can be accepted one cycle later.
REQ-015 rsp_valid=0 SHALL keep rsp_* at last value (don't-care to consumer, but must not be X after reset).
REQ-016 Operands changing on req_* after the handshake SHALL NOT affect the in-flight operation.

Reset
REQ-017 rst_n low SHALL asynchronously force the following, discarding any in-flight operation including mid-MUL:
- state=IDLE
- rsp_valid=0, rsp_data=0, rsp_cout=0, rsp_zero=0, rsp_err=0
- busy=0
- hi/lo/cnt=0
REQ-018 req_ready SHALL be 0 while rst_n is low and 1 in the first cycle after deassertion.

Structure
REQ-019 A shared package alu_seq_pkg SHALL hold the following:
- op code constants
- FSM state encoding
- 8-bit ALU control constants for each op
- MUL iteration count (16)
REQ-020 SHALL instantiate exactly one sub-module, the existing ALU16 (instance u_alu), shared between EXEC and MUL; no second adder.
REQ-021 Control-word selection SHALL be combinational from state/op/lo[0]; all outputs registered.

Verification
REQ-022 ADD A=0xFFFF, B=0x0001 -> rsp_data=0x00000000, rsp_cout=1, rsp_zero=1, rsp_valid at handshake+2.
REQ-023 SUB A=0x0005, B=0x0007 -> rsp_data=0x0000FFFE, rsp_cout=0; XOR 0xF0F0^0x0FF0 -> 0x0000FF00.
REQ-024 MUL A=0xFFFF, B=0xFFFF -> rsp_data=0xFFFE0001, rsp_valid at handshake+18, busy high throughout; MUL A=0x1234, B=0 -> 0, rsp_zero=1.
REQ-025 rsp_ready held low 10 cycles after rsp_valid -> rsp_* stable, req_ready=0, new req_valid ignored; release -> IDLE, next command accepted one cycle later.
REQ-026 rst_n pulsed low at MUL iteration 7 -> outputs cleared immediately; a subsequent ADD 2+3 returns 0x00000005 with no residue.
REQ-027 op=7 -> rsp_err=1, rsp_data=0, rsp_zero=1; a following legal op has rsp_err=0.
